// File: rtl/dot_matrix_scanner.sv
// Row scanner for an 8x8 LED dot matrix with a double-buffered frame.
// Rows advance on synchronised scan_clk rising edges; each row is preceded by a blanking gap.
module dot_matrix_scanner #(
   parameter int ROWS         = 8,
   parameter int COLS         = 8,
   parameter int BLANK_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            scan_clk,
   input  logic            wr_en,
   input  logic [2:0]      wr_row,
   input  logic [COLS-1:0] wr_data,
   input  logic            swap_req,
   output logic [ROWS-1:0] row_n,
   output logic [COLS-1:0] col,
   output logic            frame_start,
   output logic            swap_done,
   output logic            swap_pending
);
   localparam int            CW       = $clog2(BLANK_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(BLANK_CYCLES - 1);
   localparam logic [2:0]    LAST_ROW = 3'(ROWS - 1);

   typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

   state_t          r_state, w_state_nxt;
   logic [2:0]      r_row, w_row_nxt, w_row_inc;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic            r_s1, r_s2, r_s3;
   logic            w_edge, w_wrap, w_swap, w_wr_ok;
   logic            r_front_sel;
   logic [COLS-1:0] r_buf0 [ROWS];
   logic [COLS-1:0] r_buf1 [ROWS];
   logic [COLS-1:0] w_front_row;
   logic            r_frame_start, r_swap_done, r_swap_pending;

   // s1/s2 absorb metastability; s3 only delays s2 so the rising edge becomes a one-cycle pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= scan_clk;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_edge    = r_s2 & ~r_s3;
   assign w_row_inc = (r_row == LAST_ROW) ? 3'd0 : r_row + 3'd1;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      w_cnt_nxt   = r_cnt;
      w_wrap      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_edge) begin
               w_state_nxt = S_BLANK;
               w_row_nxt   = 3'd0;
               w_cnt_nxt   = CNT_LOAD;
            end
         end
         S_BLANK, S_DRIVE: begin
            // an edge always wins: it advances the row and restarts the blanking gap
            if (w_edge) begin
               w_state_nxt = S_BLANK;
               w_row_nxt   = w_row_inc;
               w_cnt_nxt   = CNT_LOAD;
               w_wrap      = (r_row == LAST_ROW);
            end else if (r_state == S_BLANK) begin
               if (r_cnt == '0) w_state_nxt = S_DRIVE;
               else             w_cnt_nxt   = r_cnt - CW'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_swap  = w_wrap & r_swap_pending;
   assign w_wr_ok = wr_en && (int'(wr_row) < ROWS);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_row          <= 3'd0;
         r_cnt          <= '0;
         r_front_sel    <= 1'b0;
         r_swap_pending <= 1'b0;
         r_swap_done    <= 1'b0;
         r_frame_start  <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_row          <= w_row_nxt;
         r_cnt          <= w_cnt_nxt;
         r_front_sel    <= r_front_sel ^ w_swap;
         r_swap_pending <= w_swap ? 1'b0 : (r_swap_pending | swap_req);
         r_swap_done    <= w_swap;
         r_frame_start  <= (w_state_nxt == S_DRIVE) && (r_state != S_DRIVE) && (w_row_nxt == 3'd0);
      end
   end

   // NOTE: both frames must clear on reset, so the buffers are reset flop arrays, not a RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ROWS; i++) begin
            r_buf0[i] <= '0;
            r_buf1[i] <= '0;
         end
      end else if (w_wr_ok) begin
         // back is whichever buffer is not front before this edge, even if a swap lands now
         if (r_front_sel) r_buf0[wr_row] <= wr_data;
         else             r_buf1[wr_row] <= wr_data;
      end
   end

   assign w_front_row = r_front_sel ? r_buf1[r_row] : r_buf0[r_row];

   always_comb begin
      row_n = '1;
      col   = '0;
      if (r_state == S_DRIVE) begin
         row_n[r_row] = 1'b0;
         col          = w_front_row;
      end
   end

   assign frame_start  = r_frame_start;
   assign swap_done    = r_swap_done;
   assign swap_pending = r_swap_pending;
endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Self-checking bench: an 8-row and a 6-row scanner share all inputs and are compared
// cycle by cycle against a frame-level model (row counter, front/back arrays, pending flag).
module tb_dot_matrix_scanner;
   logic       clk = 1'b0;
   logic       rst;
   logic       scan_clk;
   logic       wr_en;
   logic [2:0] wr_row;
   logic [7:0] wr_data;
   logic       swap_req;

   logic [7:0] row_n8, col8;
   logic       fs8, sd8, sp8;
   logic [5:0] row_n6;
   logic [7:0] col6;
   logic       fs6, sd6, sp6;

   int n_cmp  = 0;
   int n_fail = 0;

   // model state, index 0 = 8-row instance, index 1 = 6-row instance
   int         m_n [2] = '{8, 6};
   logic [7:0] m_front [2][8];
   logic [7:0] m_back  [2][8];
   int         m_row [2];
   bit         m_started [2];
   bit         m_pend [2];
   bit         m_sd [2];
   bit         m_drive;

   bit         r_wr, r_sr;
   logic [2:0] r_row;
   logic [7:0] r_data;

   always #10 clk = ~clk;

   dot_matrix_scanner #(.ROWS(8), .COLS(8), .BLANK_CYCLES(16)) u_dut8 (
      .clk(clk), .rst(rst), .scan_clk(scan_clk), .wr_en(wr_en), .wr_row(wr_row),
      .wr_data(wr_data), .swap_req(swap_req), .row_n(row_n8), .col(col8),
      .frame_start(fs8), .swap_done(sd8), .swap_pending(sp8));

   dot_matrix_scanner #(.ROWS(6), .COLS(8), .BLANK_CYCLES(16)) u_dut6 (
      .clk(clk), .rst(rst), .scan_clk(scan_clk), .wr_en(wr_en), .wr_row(wr_row),
      .wr_data(wr_data), .swap_req(swap_req), .row_n(row_n6), .col(col6),
      .frame_start(fs6), .swap_done(sd6), .swap_pending(sp6));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         for (int r = 0; r < 8; r++) begin
            m_front[i][r] = 8'h00;
            m_back[i][r]  = 8'h00;
         end
         m_row[i]     = 0;
         m_started[i] = 1'b0;
         m_pend[i]    = 1'b0;
         m_sd[i]      = 1'b0;
      end
      m_drive = 1'b0;
   endtask

   task automatic model_write(input logic [2:0] r, input logic [7:0] d);
      for (int i = 0; i < 2; i++)
         if (int'(r) < m_n[i]) m_back[i][r] = d;
   endtask

   // one scan edge as seen by a frame: write lands in old back, then row steps, then maybe swap
   task automatic model_edge(input bit do_wr, input logic [2:0] r, input logic [7:0] d, input bit sr);
      logic [7:0] tmp;
      bit         wrap;
      if (do_wr) model_write(r, d);
      for (int i = 0; i < 2; i++) begin
         wrap = 1'b0;
         if (m_started[i]) begin
            wrap     = (m_row[i] == m_n[i] - 1);
            m_row[i] = (m_row[i] + 1) % m_n[i];
         end else begin
            m_started[i] = 1'b1;
            m_row[i]     = 0;
         end
         m_sd[i] = wrap && m_pend[i];
         if (m_sd[i]) begin
            for (int k = 0; k < 8; k++) begin
               tmp           = m_front[i][k];
               m_front[i][k] = m_back[i][k];
               m_back[i][k]  = tmp;
            end
            m_pend[i] = 1'b0;
         end else if (sr) begin
            m_pend[i] = 1'b1;
         end
      end
   endtask

   task automatic check_all(input string tag, input bit drive, input bit first, input bit sd_win);
      logic [31:0] e_rn, e_col, o_rn, o_col, o_fs, o_sd, o_sp;
      for (int i = 0; i < 2; i++) begin
         e_rn = (32'd1 << m_n[i]) - 32'd1;
         if (drive) e_rn[m_row[i]] = 1'b0;
         e_col = drive ? 32'(m_front[i][m_row[i]]) : 32'd0;
         o_rn  = (i == 0) ? 32'(row_n8) : 32'(row_n6);
         o_col = (i == 0) ? 32'(col8)   : 32'(col6);
         o_fs  = (i == 0) ? 32'(fs8)    : 32'(fs6);
         o_sd  = (i == 0) ? 32'(sd8)    : 32'(sd6);
         o_sp  = (i == 0) ? 32'(sp8)    : 32'(sp6);
         check($sformatf("%s.r%0d.row_n", tag, m_n[i]), o_rn, e_rn);
         check($sformatf("%s.r%0d.col", tag, m_n[i]), o_col, e_col);
         check($sformatf("%s.r%0d.frame_start", tag, m_n[i]), o_fs,
               32'(first && drive && (m_row[i] == 0)));
         check($sformatf("%s.r%0d.swap_done", tag, m_n[i]), o_sd, 32'(sd_win && m_sd[i]));
         check($sformatf("%s.r%0d.swap_pending", tag, m_n[i]), o_sp, 32'(m_pend[i]));
      end
   endtask

   // called at a negedge; returns at the negedge right after the state update (posedge k+2)
   task automatic raise_scan(input bit do_wr, input logic [2:0] r, input logic [7:0] d, input bit sr);
      scan_clk = 1'b1;
      @(negedge clk) check_all("sync_k", m_drive, 1'b0, 1'b0);
      @(negedge clk) check_all("sync_k1", m_drive, 1'b0, 1'b0);
      wr_en    = do_wr;
      wr_row   = r;
      wr_data  = d;
      swap_req = sr;
      @(negedge clk);
      wr_en    = 1'b0;
      swap_req = 1'b0;
      scan_clk = 1'b0;
      model_edge(do_wr, r, d, sr);
      m_drive = 1'b0;
      check_all("update", 1'b0, 1'b0, 1'b1);
   endtask

   task automatic blank_then_drive();
      for (int c = 0; c < 15; c++)
         @(negedge clk) check_all("blank", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      m_drive = 1'b1;
      check_all("drive_first", 1'b1, 1'b1, 1'b0);
      @(negedge clk) check_all("drive_hold", 1'b1, 1'b0, 1'b0);
   endtask

   task automatic step_row(input bit do_wr, input logic [2:0] r, input logic [7:0] d, input bit sr);
      raise_scan(do_wr, r, d, sr);
      blank_then_drive();
   endtask

   task automatic do_write(input logic [2:0] r, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_row  = r;
      wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
      model_write(r, d);
      check_all("write", m_drive, 1'b0, 1'b0);
   endtask

   task automatic do_swap_req();
      swap_req = 1'b1;
      @(negedge clk);
      swap_req = 1'b0;
      for (int i = 0; i < 2; i++) m_pend[i] = 1'b1;
      check_all("swap_req", m_drive, 1'b0, 1'b0);
   endtask

   initial begin
      rst      = 1'b1;
      scan_clk = 1'b0;
      wr_en    = 1'b0;
      wr_row   = 3'd0;
      wr_data  = 8'h00;
      swap_req = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // idle after reset: blank, no pulses
      for (int c = 0; c < 100; c++)
         @(negedge clk) check_all("idle", 1'b0, 1'b0, 1'b0);

      // walking-one frame into back, swap, then scan through the first wrap
      for (int r = 0; r < 8; r++) do_write(3'(r), 8'h01 << r);
      do_swap_req();
      for (int e = 0; e < 9; e++) step_row(1'b0, 3'd0, 8'h00, 1'b0);
      for (int e = 0; e < 3; e++) step_row(1'b0, 3'd0, 8'h00, 1'b0);
      check("row3_row_n", 32'(row_n8), 32'hF7);
      check("row3_col", 32'(col8), 32'h08);

      // a write to a displayed row only affects back: col must stay put
      do_write(3'd3, 8'hA5);
      check("front_kept_col", 32'(col8), 32'h08);

      // randomized writes, swap requests and coincident edge traffic
      for (int it = 0; it < 24; it++) begin
         if ($urandom_range(0, 1) == 0) do_write(3'($urandom_range(0, 7)), 8'($urandom));
         if ($urandom_range(0, 3) == 0) do_swap_req();
         r_wr   = ($urandom_range(0, 3) == 0);
         r_sr   = ($urandom_range(0, 3) == 0);
         r_row  = 3'($urandom_range(0, 7));
         r_data = 8'($urandom);
         step_row(r_wr, r_row, r_data, r_sr);
      end

      // edge during blanking restarts the gap on the next row
      raise_scan(1'b0, 3'd0, 8'h00, 1'b0);
      repeat (3) @(negedge clk) check_all("blank_pre", 1'b0, 1'b0, 1'b0);
      step_row(1'b0, 3'd0, 8'h00, 1'b0);

      // swap_req in the wrap cycle is deferred; the later swap carries a coincident write
      for (int e = 0; e < 20 && !(m_row[0] == 7 && !m_pend[0]); e++)
         step_row(1'b0, 3'd0, 8'h00, 1'b0);
      check("defer_setup_row", 32'(m_row[0]), 32'd7);
      raise_scan(1'b0, 3'd0, 8'h00, 1'b1);
      check("defer_no_done", 32'(sd8), 32'd0);
      check("defer_pending", 32'(sp8), 32'd1);
      blank_then_drive();
      for (int e = 0; e < 7; e++) step_row(1'b0, 3'd0, 8'h00, 1'b0);
      r_data = 8'($urandom);
      raise_scan(1'b1, 3'd0, r_data, 1'b0);
      check("defer_done", 32'(sd8), 32'd1);
      blank_then_drive();
      check("coincident_write_col", 32'(col8), 32'(r_data));

      // async reset while driving row 4 with a pending swap
      for (int e = 0; e < 10 && m_row[0] != 4; e++) step_row(1'b0, 3'd0, 8'h00, 1'b0);
      do_swap_req();
      check("pre_rst_row_n", 32'(row_n8), 32'hEF);
      #3 rst = 1'b1;
      #2;
      model_reset();
      check_all("async_rst", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      step_row(1'b0, 3'd0, 8'h00, 1'b0);
      check("post_rst_row_n", 32'(row_n8), 32'hFE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
